// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_t : fetch FSM encodings (3 bits)
//   NOP_INST      : instruction word held in the inst register out of reset
//   PC_STEP       : sequential PC increment in bytes
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_WAIT_MEM = 3'd1,
        S_ISSUE    = 3'd2,
        S_UPDATE   = 3'd3,
        S_DRAIN    = 3'd4,
        S_HALT     = 3'd5
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          PC_STEP  = 4;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select and branch-target alignment check (purely combinational).
//   pc         in  : current PC
//   br_flag    in  : captured branch-taken flag
//   br_target  in  : captured branch target
//   next_pc    out : br_target when taken, else pc+PC_STEP (wraps)
//   misaligned out : taken branch to a non word-aligned target
module pc_next_logic
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  br_flag,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  misaligned
);

    logic [ADDR_WIDTH-1:0] seq_pc;

    // Plain modular add: wrapping past the top of the address space is intended.
    assign seq_pc     = pc + ADDR_WIDTH'(PC_STEP);
    assign next_pc    = br_flag ? br_target : seq_pc;
    assign misaligned = br_flag && (br_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory and hands it to decode, then advances the PC.
//   clk, rst       : clock, synchronous active-high reset
//   imem_req/addr  : memory read request, address always equals pc
//   imem_rdata/valid : memory response, only accepted while waiting for it
//   inst           : registered instruction presented to decode
//   compute_req    : instruction available to decode
//   compute_valid  : decode done; branch_flag/branch_target sampled with it
//   pc             : current PC
//   fault          : sticky misaligned-branch-target fault (core halts)
//   instr_count    : retired instruction counter (wraps)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  compute_req,
    input  logic                  compute_valid,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  fault,
    output logic [31:0]           instr_count
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] inst_q;
    logic                  fault_q;
    logic [31:0]           count_q;
    logic                  br_flag_q;
    logic [ADDR_WIDTH-1:0] br_target_q;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  misaligned;

    pc_next_logic #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
        .pc         (pc_q),
        .br_flag    (br_flag_q),
        .br_target  (br_target_q),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        compute_req = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                state_d  = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                imem_req = 1'b1;
                if (imem_valid) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                compute_req = 1'b1;
                if (compute_valid) state_d = S_UPDATE;
            end
            S_UPDATE: state_d = misaligned ? S_HALT : S_DRAIN;
            // Decode keeps compute_valid up one cycle past compute_req; wait it
            // out so the same completion is not seen twice.
            S_DRAIN:  if (!compute_valid) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        // Reset state is S_FETCH, but no request may be raised while rst is held.
        if (rst) begin
            imem_req    = 1'b0;
            compute_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= DATA_WIDTH'(NOP_INST);
            fault_q     <= 1'b0;
            count_q     <= '0;
            br_flag_q   <= 1'b0;
            br_target_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_WAIT_MEM: if (imem_valid) inst_q <= imem_rdata;
                S_ISSUE: if (compute_valid) begin
                    br_flag_q   <= branch_flag;
                    br_target_q <= branch_target;
                    count_q     <= count_q + 32'd1;
                end
                S_UPDATE: begin
                    if (misaligned) fault_q <= 1'b1;
                    else            pc_q    <= next_pc;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign inst        = inst_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule
